// File: rtl/mem_output_logic.sv
// rtl/mem_output_logic.sv - load-return stage: request tracking, lane unswap, extension
// Captures the access in cycle N and returns the aligned result in N+1, frozen while stalled.
module mem_output_logic (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [1:0]  memOp,
  input  logic [1:0]  memSize,
  input  logic        enRam,
  input  logic        enDin,
  input  logic        stall,
  input  logic [31:0] ramDout,
  input  logic [31:0] dinReg,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        misaligned
);

  localparam logic [1:0] MEM_DISABLE   = 2'b00;
  localparam logic [1:0] MEM_READ_SEXT = 2'b01;
  localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
  localparam logic [1:0] BYTE          = 2'b00;
  localparam logic [1:0] HALFWORD      = 2'b01;
  localparam logic [1:0] WORD          = 2'b10;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_RAM  = 2'b01,
    SRC_DIN  = 2'b10
  } src_e;

  typedef struct packed {
    logic        vld;
    logic        sext;
    logic [1:0]  size;
    logic [1:0]  off;
    src_e        src;
    logic [31:0] din_cap;
    logic        mis;
  } req_t;

  req_t        req_q, req_d;
  logic        hold_q, hold_d;
  logic [31:0] hold_reg_q, hold_reg_d;

  logic        is_read;
  logic        mis_now;
  logic [31:0] ram_native;
  logic [31:0] src_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] aligned;
  logic        unused_addr;

  assign unused_addr = ^addr[31:2];

  always_comb begin
    is_read = (memOp == MEM_READ_SEXT) || (memOp == MEM_READ_ZEXT);
    mis_now = (memOp != MEM_DISABLE) &&
              (((memSize == HALFWORD) && addr[0]) ||
               ((memSize == WORD) && (addr[1:0] != 2'b00)) ||
               (memSize == 2'b11));
    req_d         = '0;
    req_d.mis     = mis_now;
    req_d.vld     = is_read && !mis_now;
    req_d.sext    = (memOp == MEM_READ_SEXT);
    req_d.size    = memSize;
    req_d.off     = addr[1:0];
    req_d.din_cap = dinReg;
    if (enRam) begin
      req_d.src = SRC_RAM;
    end else if (enDin) begin
      req_d.src = SRC_DIN;
    end else begin
      req_d.src = SRC_NONE;
    end
  end

  // BRAM stores byte k in lane 3-k; restore native order so both sources share one extractor.
  always_comb begin
    ram_native = {ramDout[7:0], ramDout[15:8], ramDout[23:16], ramDout[31:24]};
    case (req_q.src)
      SRC_RAM: src_word = ram_native;
      SRC_DIN: src_word = req_q.din_cap;
      default: src_word = 32'h0;
    endcase
    byte_sel = src_word[{req_q.off, 3'b000} +: 8];
    half_sel = src_word[{req_q.off[1], 4'b0000} +: 16];
    case (req_q.size)
      BYTE:     aligned = {{24{req_q.sext & byte_sel[7]}}, byte_sel};
      HALFWORD: aligned = {{16{req_q.sext & half_sel[15]}}, half_sel};
      default:  aligned = src_word;
    endcase
  end

  always_comb begin
    hold_d     = hold_q;
    hold_reg_d = hold_reg_q;
    if (!stall) begin
      hold_d = 1'b0;
    end else if (req_q.vld && !hold_q) begin
      hold_d     = 1'b1;
      hold_reg_d = aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      req_q      <= '0;
      hold_q     <= 1'b0;
      hold_reg_q <= 32'h0;
    end else begin
      if (!stall) begin
        req_q <= req_d;
      end
      hold_q     <= hold_d;
      hold_reg_q <= hold_reg_d;
    end
  end

  always_comb begin
    loadValid  = hold_q | req_q.vld;
    misaligned = req_q.mis;
    if (hold_q) begin
      loadData = hold_reg_q;
    end else if (req_q.vld) begin
      loadData = aligned;
    end else begin
      loadData = 32'h0;
    end
  end

endmodule

// File: doc/mem_output_logic.md
Name: mem_output_logic

Overview:
Load-return stage directly downstream of the memory input logic and the CPU BRAM port B. It captures the read request in the access cycle and tracks it across the 1-cycle BRAM read latency. It then selects the source (BRAM or DIN MMIO register), undoes the byte-lane swap applied on the write side, and sign- or zero-extends the result. Stall-safe hold logic keeps returned data stable while the pipeline is frozen.

Parameters:
MEM_DISABLE, 2'b00, memOp encoding: no access
MEM_READ_SEXT, 2'b01, memOp encoding: sign-extending load
MEM_READ_ZEXT, 2'b10, memOp encoding: zero-extending load
MEM_WRITE, 2'b11, memOp encoding: store
BYTE, 2'b00, memSize encoding: 8-bit access
HALFWORD, 2'b01, memSize encoding: 16-bit access
WORD, 2'b10, memSize encoding: 32-bit access

Ports:
clk  input  1  single clock; all state on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
addr  input  32  byte address of current access (cycle N)
memOp  input  2  operation of current access
memSize  input  2  size of current access
enRam  input  1  decoded BRAM select from the input stage
enDin  input  1  decoded DIN-register read select from the input stage
stall  input  1  pipeline freeze; no new request accepted, output held
ramDout  input  32  BRAM port B read data, valid cycle N+1, byte-swapped lanes
dinReg  input  32  DIN MMIO register value, native little-endian order
loadData  output  32  aligned, extended load result
loadValid  output  1  loadData is valid this cycle
misaligned  output  1  fault flag for the request issued in cycle N, shown in N+1

Behaviour:
- Reset (reset==0 at an edge) clears the request register, hold flag and hold register. loadValid=0, misaligned=0, loadData=0. A pending request is dropped, and no loadValid follows reset release.
- Request register fields: vld, sext, size, off[1:0], src{RAM,DIN,NONE}, dinCap[31:0], mis.
- Update rule: the register updates only when stall==0; under stall it holds.
  - isRead = memOp is SEXT or ZEXT.
  - mis = (size==HALFWORD && addr[0]) || (size==WORD && addr[1:0]!=0) || size==2'b11. Applies to reads and writes; MEM_DISABLE never faults.
  - vld = isRead && !mis.
  - src = RAM if enRam, else DIN if enDin, else NONE. enRam takes priority if both are set.
  - dinCap is sampled from dinReg in cycle N.
- Latency: data appears exactly 1 cycle after the request. loadValid = vld, misaligned = mis (registered, cycle N+1).
- RAM extraction uses stored byte k in lane 3-k:
  - WORD: {d[7:0],d[15:8],d[23:16],d[31:24]}.
  - HALFWORD: off[1]=0 gives {d[23:16],d[31:24]}; off[1]=1 gives {d[7:0],d[15:8]}.
  - BYTE: off k gives d[31-8k -: 8].
- DIN extraction uses native order: byte k = dinCap[8k+7:8k]; halfword = dinCap[16*off[1]+15 -: 16]; word = dinCap.
- Extension: sext replicates bit 7 (byte) or bit 15 (half); zext pads with zeros. WORD is unaffected.
- src NONE with vld: loadValid=1, loadData=0.
- When loadValid==0, loadData=0.
- Stall hold:
  - On the first stalled cycle with vld=1, the aligned result is captured into holdReg and hold is set.
  - While hold is set, loadData=holdReg regardless of ramDout changes, and loadValid stays 1.
  - The first cycle with stall==0 clears hold and accepts the next request. The held result is presented once more that cycle, then replaced next cycle.
- Back-to-back reads stream at 1 per cycle with no bubbles.
- Writes produce no loadValid. A misaligned write still pulses misaligned.

Test Plan:
1. Store word 0x8000_12F0 to 0x10 (BRAM holds 0xF012_0080), then lb 0x10, lbu 0x11, lh 0x12, lhu 0x12, lw 0x10 back-to-back -> results 0xFFFF_FFF0, 0x0000_0012, 0xFFFF_8000, 0x0000_8000, 0x8000_12F0 on 5 consecutive cycles, with loadValid high each cycle.
2. lh 0x11 and lw 0x12 -> misaligned=1 and loadValid=0 in N+1. sb 0x13 -> misaligned=0.
3. dinReg=0xCAFE_BA80, lb DIN_REG+0 (sext) with enDin -> 0xFFFF_FF80. dinReg changes to 0 in N+1 -> result unchanged.
4. lw 0x10 then stall for 3 cycles while ramDout is forced to 0x1234_5678 -> loadData=0x8000_12F0 and loadValid=1 across all stalled cycles and the release cycle.
5. Assert reset low in cycle N+1 of a lw -> loadValid=0 and loadData=0 the following cycle. No stale valid after release.
6. Read of an unmapped address 0x0300_0000 (enRam=enDin=0) -> loadValid=1, loadData=0x0000_0000.
